// File: rtl/hit_pulse_gen.sv
// Trapezoidal test-pulse source feeding the hit detector sample stream; one sample every cfg_div+1 clocks,
// first sample cfg_div+1 clocks after start is accepted; no backpressure, cfg_en low aborts on the next edge.
module hit_pulse_gen #(
  parameter int DW = 16,
  parameter int GW = 32
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          cfg_en,
  input  logic          start,
  input  logic [15:0]   cfg_div,
  input  logic [DW-1:0] cfg_base,
  input  logic [DW-1:0] cfg_amp,
  input  logic [DW-1:0] cfg_step,
  input  logic [15:0]   cfg_top,
  input  logic [GW-1:0] cfg_gap,
  input  logic [15:0]   cfg_num,
  output logic [DW-1:0] sm_data,
  output logic          sm_vld,
  output logic          stu_busy,
  output logic [15:0]   stu_pulse_cnt,
  output logic          done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RISE = 3'd1;
  localparam logic [2:0] S_TOP  = 3'd2;
  localparam logic [2:0] S_FALL = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [15:0]   cnt_div_q, cnt_div_d;
  logic [15:0]   div_q, div_d;
  logic [DW-1:0] base_q, base_d;
  logic [DW-1:0] peak_q, peak_d;
  logic [DW-1:0] step_q, step_d;
  logic [15:0]   top_q, top_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   num_q, num_d;
  logic [DW-1:0] level_q, level_d;
  logic [15:0]   cnt_top_q, cnt_top_d;
  logic [GW-1:0] cnt_gap_q, cnt_gap_d;
  logic [15:0]   pulse_cnt_q, pulse_cnt_d;
  logic [DW-1:0] sm_data_q, sm_data_d;
  logic          sm_vld_q, sm_vld_d;
  logic          done_q, done_d;

  logic          strobe;
  logic [DW:0]   sum_bp;
  logic [DW:0]   sum_r;
  logic [DW:0]   diff_f;
  logic [DW-1:0] rise_n;
  logic [DW-1:0] fall_n;

  assign strobe = (state_q != S_IDLE) && (cnt_div_q == div_q);

  // Sums carry one extra bit so saturation is decided before any wrap.
  assign sum_bp = {1'b0, cfg_base} + {1'b0, cfg_amp};
  assign sum_r  = {1'b0, level_q} + {1'b0, step_q};
  assign diff_f = {1'b0, level_q} - {1'b0, step_q};
  assign rise_n = (sum_r > {1'b0, peak_q}) ? peak_q : sum_r[DW-1:0];
  assign fall_n = (diff_f[DW] || (diff_f[DW-1:0] < base_q)) ? base_q : diff_f[DW-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_div_d   = cnt_div_q;
    div_d       = div_q;
    base_d      = base_q;
    peak_d      = peak_q;
    step_d      = step_q;
    top_d       = top_q;
    gap_d       = gap_q;
    num_d       = num_q;
    level_d     = level_q;
    cnt_top_d   = cnt_top_q;
    cnt_gap_d   = cnt_gap_q;
    pulse_cnt_d = pulse_cnt_q;
    sm_data_d   = sm_data_q;
    sm_vld_d    = 1'b0;
    done_d      = 1'b0;

    if (state_q == S_IDLE) begin
      if (start && cfg_en) begin
        div_d       = cfg_div;
        base_d      = cfg_base;
        peak_d      = sum_bp[DW] ? {DW{1'b1}} : sum_bp[DW-1:0];
        step_d      = (cfg_step != '0) ? cfg_step :
                      ((cfg_amp != '0) ? cfg_amp : DW'(1));
        top_d       = cfg_top;
        gap_d       = cfg_gap;
        num_d       = cfg_num;
        level_d     = cfg_base;
        pulse_cnt_d = '0;
        cnt_div_d   = '0;
        cnt_top_d   = '0;
        cnt_gap_d   = '0;
        state_d     = S_RISE;
      end
    end else if (!cfg_en) begin
      // Abort takes priority over a coincident strobe: no sample, no done.
      state_d = S_IDLE;
    end else begin
      cnt_div_d = strobe ? 16'd0 : cnt_div_q + 16'd1;
      case (state_q)
        S_RISE: begin
          if (strobe) begin
            level_d   = rise_n;
            sm_data_d = rise_n;
            sm_vld_d  = 1'b1;
            if (rise_n == peak_q) begin
              cnt_top_d = '0;
              state_d   = (top_q == 16'd0) ? S_FALL : S_TOP;
            end
          end
        end
        S_TOP: begin
          if (strobe) begin
            sm_data_d = peak_q;
            sm_vld_d  = 1'b1;
            cnt_top_d = cnt_top_q + 16'd1;
            if (cnt_top_q + 16'd1 == top_q) begin
              state_d = S_FALL;
            end
          end
        end
        S_FALL: begin
          if (strobe) begin
            level_d   = fall_n;
            sm_data_d = fall_n;
            sm_vld_d  = 1'b1;
            if (fall_n == base_q) begin
              pulse_cnt_d = pulse_cnt_q + 16'd1;
              cnt_gap_d   = '0;
              if ((num_q != 16'd0) && (pulse_cnt_q + 16'd1 == num_q)) begin
                state_d = S_DONE;
              end else if (gap_q == '0) begin
                state_d = S_RISE;
              end else begin
                state_d = S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (strobe) begin
            sm_data_d = base_q;
            sm_vld_d  = 1'b1;
            if (cnt_gap_q + GW'(1) == gap_q) begin
              cnt_gap_d = '0;
              state_d   = S_RISE;
            end else begin
              cnt_gap_d = cnt_gap_q + GW'(1);
            end
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_div_q   <= '0;
      div_q       <= '0;
      base_q      <= '0;
      peak_q      <= '0;
      step_q      <= '0;
      top_q       <= '0;
      gap_q       <= '0;
      num_q       <= '0;
      level_q     <= '0;
      cnt_top_q   <= '0;
      cnt_gap_q   <= '0;
      pulse_cnt_q <= '0;
      sm_data_q   <= '0;
      sm_vld_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_div_q   <= cnt_div_d;
      div_q       <= div_d;
      base_q      <= base_d;
      peak_q      <= peak_d;
      step_q      <= step_d;
      top_q       <= top_d;
      gap_q       <= gap_d;
      num_q       <= num_d;
      level_q     <= level_d;
      cnt_top_q   <= cnt_top_d;
      cnt_gap_q   <= cnt_gap_d;
      pulse_cnt_q <= pulse_cnt_d;
      sm_data_q   <= sm_data_d;
      sm_vld_q    <= sm_vld_d;
      done_q      <= done_d;
    end
  end

  assign sm_data       = sm_data_q;
  assign sm_vld        = sm_vld_q;
  assign done          = done_q;
  assign stu_pulse_cnt = pulse_cnt_q;
  // done is registered one clock after S_DONE; busy covers that clock so it drops right after done.
  assign stu_busy      = (state_q != S_IDLE) || done_q;

endmodule

// File: tb/tb_hit_pulse_gen.sv
// Bench for hit_pulse_gen: directed test-plan bursts plus randomized configs, checked cycle by cycle
// against a sample-list model built from the pulse-shape rules.
module tb_hit_pulse_gen;
  localparam int DW = 16;
  localparam int GW = 32;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic          cfg_en;
  logic          start;
  logic [15:0]   cfg_div;
  logic [DW-1:0] cfg_base;
  logic [DW-1:0] cfg_amp;
  logic [DW-1:0] cfg_step;
  logic [15:0]   cfg_top;
  logic [GW-1:0] cfg_gap;
  logic [15:0]   cfg_num;
  logic [DW-1:0] sm_data;
  logic          sm_vld;
  logic          stu_busy;
  logic [15:0]   stu_pulse_cnt;
  logic          done;

  int n_chk = 0;
  int n_err = 0;
  int pat[$];
  int plen;

  hit_pulse_gen #(.DW(DW), .GW(GW)) u_dut (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .cfg_en        (cfg_en),
    .start         (start),
    .cfg_div       (cfg_div),
    .cfg_base      (cfg_base),
    .cfg_amp       (cfg_amp),
    .cfg_step      (cfg_step),
    .cfg_top       (cfg_top),
    .cfg_gap       (cfg_gap),
    .cfg_num       (cfg_num),
    .sm_data       (sm_data),
    .sm_vld        (sm_vld),
    .stu_busy      (stu_busy),
    .stu_pulse_cnt (stu_pulse_cnt),
    .done          (done)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One pulse (rise, top, fall) followed by its gap, straight from the shape rules.
  task automatic build_model();
    int b, a, s, pk, lvl, maxv;
    maxv = (1 << DW) - 1;
    b    = int'(cfg_base);
    a    = int'(cfg_amp);
    s    = (cfg_step != 0) ? int'(cfg_step) : ((a != 0) ? a : 1);
    pk   = (b + a > maxv) ? maxv : b + a;
    pat.delete();
    lvl = b;
    do begin
      lvl = (lvl + s > pk) ? pk : lvl + s;
      pat.push_back(lvl);
    end while (lvl != pk);
    for (int i = 0; i < int'(cfg_top); i++) pat.push_back(pk);
    do begin
      lvl = (lvl - s < b) ? b : lvl - s;
      pat.push_back(lvl);
    end while (lvl != b);
    plen = pat.size();
    for (int i = 0; i < int'(cfg_gap); i++) pat.push_back(b);
  endtask

  function automatic int done_pulses(input int m);
    if (m < plen) return 0;
    return ((m - plen) / pat.size() + 1) & 16'hFFFF;
  endfunction

  task automatic set_cfg(input int dv, input int bs, input int am, input int st,
                         input int tp, input int gp, input int nm);
    cfg_div  = 16'(dv);
    cfg_base = DW'(bs);
    cfg_amp  = DW'(am);
    cfg_step = DW'(st);
    cfg_top  = 16'(tp);
    cfg_gap  = GW'(gp);
    cfg_num  = 16'(nm);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_vld"},  {31'd0, sm_vld},   0);
    chk({tag, "_data"}, {16'd0, sm_data},  0);
    chk({tag, "_busy"}, {31'd0, stu_busy}, 0);
    chk({tag, "_pcnt"}, {16'd0, stu_pulse_cnt}, 0);
    chk({tag, "_done"}, {31'd0, done},     0);
  endtask

  // Runs one burst; k counts clock edges after the start-accept edge.
  // Optional events (-1 = none): abort_k drops cfg_en, start_k re-pulses start,
  // amp_k perturbs cfg_amp, rst_k asserts reset.
  task automatic run(input int abort_k, input int start_k, input int amp_k,
                     input int rst_k, input int max_k);
    int per, n, kend, m, nsz;
    bit aborted;
    logic [15:0] num_s;
    bit evld, edone, ebusy;
    aborted = 1'b0;
    m       = 0;
    num_s   = cfg_num;
    build_model();
    nsz  = pat.size();
    per  = int'(cfg_div) + 1;
    n    = (num_s == 0) ? 32'h3FFF_FFFF : int'(num_s) * plen + (int'(num_s) - 1) * int'(cfg_gap);
    kend = (num_s == 0) ? max_k : n * per + 2;
    @(negedge clk_sys) start = 1'b1;
    @(negedge clk_sys) start = 1'b0;
    for (int k = 1; k <= kend; k++) begin
      @(negedge clk_sys);
      if (aborted) begin
        chk("abort_vld",  {31'd0, sm_vld},   0);
        chk("abort_busy", {31'd0, stu_busy}, 0);
        chk("abort_done", {31'd0, done},     0);
        chk("abort_pcnt", {16'd0, stu_pulse_cnt}, done_pulses(m));
        if (m > 0) chk("abort_hold", {16'd0, sm_data}, pat[(m - 1) % nsz]);
      end else begin
        m = k / per;
        if (num_s != 0 && m > n) m = n;
        evld  = (k % per == 0) && (num_s == 0 || k / per <= n);
        edone = (num_s != 0) && (k == n * per + 1);
        ebusy = (num_s == 0) || (k <= n * per + 1);
        chk("vld",  {31'd0, sm_vld},   evld);
        if (evld) chk("data", {16'd0, sm_data}, pat[(k / per - 1) % nsz]);
        chk("done", {31'd0, done},     edone);
        chk("busy", {31'd0, stu_busy}, ebusy);
        chk("pcnt", {16'd0, stu_pulse_cnt}, done_pulses(m));
      end
      start = (k == start_k);
      if (k == amp_k) cfg_amp = cfg_amp ^ DW'(16'h0155);
      if (k == abort_k) begin
        cfg_en  = 1'b0;
        aborted = 1'b1;
      end
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_rst");
        @(negedge clk_sys) rst_n = 1'b1;
        break;
      end
    end
    start  = 1'b0;
    cfg_en = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    cfg_en = 1'b1;
    start  = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk_sys);
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk_sys);
    chk_reset_state("post_reset");

    // basic burst, then the same through the divider
    set_cfg(0, 100, 400, 100, 2, 3, 2);
    run(-1, -1, -1, -1, 0);
    set_cfg(3, 100, 400, 100, 2, 3, 2);
    run(-1, -1, -1, -1, 0);
    // saturation at full scale
    set_cfg(0, 16'hFF00, 16'h0200, 16'h0080, 0, 0, 1);
    run(-1, -1, -1, -1, 0);
    // instant edges, then zero amplitude
    set_cfg(0, 10, 50, 0, 1, 0, 1);
    run(-1, -1, -1, -1, 0);
    set_cfg(1, 7, 0, 0, 1, 1, 2);
    run(-1, -1, -1, -1, 0);
    // continuous: ignored start, amp change, abort while at the flat top of pulse 2
    set_cfg(0, 100, 400, 100, 2, 3, 0);
    run(17, 8, 5, -1, 30);
    // reset asserted mid-fall
    set_cfg(0, 100, 400, 100, 2, 3, 2);
    run(-1, -1, -1, 8, 0);
    @(negedge clk_sys);
    chk_reset_state("after_rst");

    for (int t = 0; t < 20; t++) begin
      set_cfg($urandom_range(0, 2),
              $urandom_range(0, 1) ? $urandom_range(0, 65535) : $urandom_range(65000, 65535),
              $urandom_range(0, 200),
              $urandom_range(0, 12) * 8,
              $urandom_range(0, 3),
              $urandom_range(0, 3),
              $urandom_range(1, 3));
      run(-1, 2, 1, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
